// File: rtl/id_ex_stage.sv
//==============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register for the pipelined MIPS core. Captures
//               decoded operands, immediate, register addresses and control
//               bits from decode and holds them for execute. Supports stall
//               (hold) and flush (bubble). Generates the load-use stall
//               request and the packed bus / 2-bit select pairs that drive
//               the downstream 3-input ALU operand muxes.
// Config      : ID_EX_FWD_EN - when defined, forwarding selects are computed
//               from the EX/MEM and MEM/WB destinations; when undefined the
//               selects are tied to 2'b00 and the hazard stage handles all
//               RAW dependencies by stalling.
// Ports       :
//   clk, rst                         clock, async active-high reset
//   stall, flush                     hold / bubble controls (flush wins)
//   id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_ctrl
//                                    decode-stage values to capture
//   exmem_rd/_reg_write/_result      EX/MEM destination, enable, result
//   memwb_rd/_reg_write/_result      MEM/WB destination, enable, result
//   ex_valid, ex_imm, ex_rd, ex_ctrl registered execute-stage values
//   ex_fwdA_bus, ex_fwdB_bus         {memwb_result, exmem_result, operand}
//   ex_fwdA_sel, ex_fwdB_sel         operand mux selects
//   load_use_stall                   hazard request to PC / IF-ID
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int BIT_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 8,
    parameter int MEMREAD_BIT    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [BIT_WIDTH-1:0]      id_rs_data,
    input  logic [BIT_WIDTH-1:0]      id_rt_data,
    input  logic [BIT_WIDTH-1:0]      id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      exmem_reg_write,
    input  logic                      memwb_reg_write,
    input  logic [BIT_WIDTH-1:0]      exmem_result,
    input  logic [BIT_WIDTH-1:0]      memwb_result,
    output logic                      ex_valid,
    output logic [BIT_WIDTH-1:0]      ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [CTRL_WIDTH-1:0]     ex_ctrl,
    output logic [3*BIT_WIDTH-1:0]    ex_fwdA_bus,
    output logic [3*BIT_WIDTH-1:0]    ex_fwdB_bus,
    output logic [1:0]                ex_fwdA_sel,
    output logic [1:0]                ex_fwdB_sel,
    output logic                      load_use_stall
);

    localparam logic [1:0] c_SEL_REG   = 2'b00;
    localparam logic [1:0] c_SEL_EXMEM = 2'b01;
    localparam logic [1:0] c_SEL_MEMWB = 2'b10;

    //--------------------------------------------------------------------------
    // Pipeline registers
    //--------------------------------------------------------------------------
    logic                      valid_q,   valid_d;
    logic [BIT_WIDTH-1:0]      rs_data_q, rs_data_d;
    logic [BIT_WIDTH-1:0]      rt_data_q, rt_data_d;
    logic [BIT_WIDTH-1:0]      imm_q,     imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q,      rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q,      rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q,    ctrl_d;

    // Flush outranks stall so a bubble can be inserted even while the
    // pipeline is frozen.
    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        if (flush) begin
            valid_d   = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            ctrl_d    = '0;
        end else if (!stall) begin
            valid_d   = id_valid;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_imm   = imm_q;
    assign ex_rd    = rd_q;
    assign ex_ctrl  = ctrl_q;

    // Mux input order: slice 0 = register operand, 1 = EX/MEM, 2 = MEM/WB.
    assign ex_fwdA_bus = {memwb_result, exmem_result, rs_data_q};
    assign ex_fwdB_bus = {memwb_result, exmem_result, rt_data_q};

    //--------------------------------------------------------------------------
    // Forwarding selects
    //--------------------------------------------------------------------------
`ifdef ID_EX_FWD_EN
    // Destination register 0 never matches, so a source of 0 can never be
    // forwarded either.
    logic w_exmem_live;
    logic w_memwb_live;
    assign w_exmem_live = exmem_reg_write && (exmem_rd != '0);
    assign w_memwb_live = memwb_reg_write && (memwb_rd != '0);

    always_comb begin
        ex_fwdA_sel = c_SEL_REG;
        ex_fwdB_sel = c_SEL_REG;
        if (valid_q) begin
            // EX/MEM holds the younger result, so it is checked first.
            if (w_exmem_live && (exmem_rd == rs_q))
                ex_fwdA_sel = c_SEL_EXMEM;
            else if (w_memwb_live && (memwb_rd == rs_q))
                ex_fwdA_sel = c_SEL_MEMWB;

            if (w_exmem_live && (exmem_rd == rt_q))
                ex_fwdB_sel = c_SEL_EXMEM;
            else if (w_memwb_live && (memwb_rd == rt_q))
                ex_fwdB_sel = c_SEL_MEMWB;
        end
    end
`else
    // Without forwarding the hazard stage resolves every RAW dependency, so
    // the operand muxes always take the register-file value.
    assign ex_fwdA_sel = c_SEL_REG;
    assign ex_fwdB_sel = c_SEL_REG;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_rd, memwb_rd, exmem_reg_write,
                            memwb_reg_write, rs_q, rt_q,
                            c_SEL_EXMEM, c_SEL_MEMWB};
`endif

    //--------------------------------------------------------------------------
    // Load-use hazard: the load in execute has not produced its data yet, so
    // a decode instruction reading that register must wait one cycle.
    // id_valid is deliberately ignored; stalling an empty slot is harmless.
    //--------------------------------------------------------------------------
    assign load_use_stall = valid_q && ctrl_q[MEMREAD_BIT] && (rd_q != '0) &&
                            ((rd_q == id_rs) || (rd_q == id_rt));

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined MIPS core. It captures decoded operands, immediate, register addresses and control bits from the decode stage and holds them for execute. It supports stall (hold) and flush (bubble insertion) and generates the load-use stall request. It also produces the packed data buses and 2-bit select values that drive the ALU operand-A and operand-B `mux` instances (DEPTH=3, SEL_WIDTH=2) directly downstream.

## Interface
Parameters:
- BIT_WIDTH, 32, datapath width
- REG_ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 8, control bundle width
- MEMREAD_BIT, 0, index in ctrl of the load (mem-read) flag

Ports. Clock is `clk`; reset is `rst`, asynchronous, active-high:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- stall  in  1  hold all registers
- flush  in  1  load a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data, id_rt_data  in  BIT_WIDTH  register file read data
- id_imm  in  BIT_WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH  source/dest addresses
- id_ctrl  in  CTRL_WIDTH  decoded control
- exmem_rd, memwb_rd  in  REG_ADDR_WIDTH  downstream destinations
- exmem_reg_write, memwb_reg_write  in  1  downstream write enables
- exmem_result, memwb_result  in  BIT_WIDTH  downstream results
- ex_valid  out  1  execute slot valid
- ex_imm, ex_rd, ex_ctrl  out  widths as inputs  registered copies
- ex_fwdA_bus, ex_fwdB_bus  out  3*BIT_WIDTH  {memwb_result, exmem_result, ex_rs_data / ex_rt_data}; slice 0 in the LSBs
- ex_fwdA_sel, ex_fwdB_sel  out  2  mux selects
- load_use_stall  out  1  hazard request to the PC/IF-ID stage

## Operation
- Each rising edge, priority order:
  - rst: every register is 0.
  - flush: ex_valid is 0 and ex_ctrl is 0. Data and address registers are 0.
  - stall: all registers hold.
  - otherwise: all id_* values load into ex_*, and ex_valid loads id_valid.
- flush with stall asserted together: flush wins.
- Forwarding select for ex_fwdA_sel; ex_fwdB_sel is the same using ex_rt:
  - 2'b01 if exmem_reg_write, exmem_rd≠0 and exmem_rd==ex_rs.
  - else 2'b10 if memwb_reg_write, memwb_rd≠0 and memwb_rd==ex_rs.
  - else 2'b00.
  - EX/MEM has priority over MEM/WB.
  - 2'b11 is never produced.
- Selects are forced to 00 when ex_valid=0.
- load_use_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & ex_rd≠0 & (ex_rd==id_rs | ex_rd==id_rt).
  - Ignores id_valid; a spurious stall on an invalid slot is harmless.
- Register 0 is never a hazard or forwarding source.
- All arithmetic is equality compares only. There are no width changes; buses are concatenations.

## Timing
- Latency: one cycle, ID inputs to ex_* outputs.
- ex_fwd*_sel, ex_fwd*_bus and load_use_stall are combinational from registered state and same-cycle downstream inputs. There is no extra latency.
- Reset values: all outputs 0.
  - This follows because selects read 00 and the buses carry only live exmem/memwb inputs, which are 0 under system reset.
- Reset mid-operation clears state immediately, without waiting for a clock edge.
- Stall held for N cycles: outputs are stable for N cycles, and selects still track downstream changes.

## Configuration
- Macro: ID_EX_FWD_EN.
- Defined: forwarding select logic as described above.
- Not defined: ex_fwdA_sel and ex_fwdB_sel are tied to 2'b00, and the buses are still driven.
  - load_use_stall is unchanged.
  - The pipeline then relies on the hazard stage for all RAW stalls.

## Test plan
- Reset: assert rst mid-cycle with all registers loaded -> all outputs are 0 before the next edge.
- Load then stall: load id_rs_data=0x1234, then stall=1 for 3 cycles while id_rs_data=0xFFFF -> ex_rs_data slice stays 0x1234. The value updates on the first edge after stall=0.
- Flush with stall: stall=1 and flush=1 -> ex_valid=0, ex_ctrl=0 after the edge.
- Forwarding priority: ex_rs=5, exmem_rd=5, exmem_reg_write=1, memwb_rd=5, memwb_reg_write=1 -> ex_fwdA_sel=01.
  - With exmem_reg_write=0 -> 10.
  - With ex_rs=0 in either case -> 00.
- Load-use: ex_valid=1, ex_ctrl[0]=1, ex_rd=8, id_rt=8 -> load_use_stall=1. With id_rt=9 and id_rs=9 -> 0.
- Macro undefined: same stimulus as the forwarding-priority case -> selects read 00.
